// File: rtl/mul16_pkg.sv
// rtl/mul16_pkg.sv - shared types and constants for the sequential 16x16 multiplier
package mul16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul16_seq_if.sv
// rtl/mul16_seq_if.sv - start/ready/done handshake between datapath controller and multiplier
interface mul16_seq_if;
    import mul16_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output start, A, B,
        input  ready, busy, done, P
    );

    modport slave (
        input  start, A, B,
        output ready, busy, done, P
    );

endinterface

// File: rtl/Add16.sv
// rtl/Add16.sv - 16-bit adder returning sum and carry-out
module Add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - 16x16 unsigned shift-and-add multiplier, one partial product per clock
module mul16_seq
    import mul16_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mul16_seq_if.slave   bus
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   p_q;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 carry;
    logic [2*WIDTH-1:0]   acc_shift;

    // start is only honoured while ready (IDLE or DONE)
    assign accept    = bus.start && (state_q != RUN);
    assign last_iter = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign addend    = acc_q[0] ? mcand_q : '0;

    Add16 u_add (
        .a_i (acc_q[2*WIDTH-1:WIDTH]),
        .b_i (addend),
        .s_o (sum),
        .c_o (carry)
    );

    // The 33rd shift bit is always zero, so the carry lands directly in bit 31
    assign acc_shift = {carry, sum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_q == IDLE) || (state_q == DONE);
        bus.busy  = (state_q == RUN);
        bus.done  = (state_q == DONE);
        bus.P     = p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else if (accept) begin
            mcand_q <= bus.A;
            acc_q   <= {{WIDTH{1'b0}}, bus.B};
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q <= acc_shift;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                p_q <= acc_shift;
            end
        end
    end

endmodule
